// File: rtl/denise_colortable_ram_mf.sv
// rtl/denise_colortable_ram_mf.sv - 256x24 simple dual-port colour table RAM with half-word write enables
// Two 12-bit arrays share the addresses; only the registered read port sees the async clear.
module denise_colortable_ram_mf #(
  parameter int ADDR_WIDTH = 8,
  parameter int HALF_WIDTH = 12
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wraddress,
  input  logic                    wren,
  input  logic [1:0]              ena_a,
  input  logic [HALF_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   rdaddress,
  output logic [2*HALF_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [HALF_WIDTH-1:0]   mem_hi_q [DEPTH];
  logic [HALF_WIDTH-1:0]   mem_lo_q [DEPTH];
  logic [2*HALF_WIDTH-1:0] q_q;
  logic [2*HALF_WIDTH-1:0] q_d;
  logic                    we_hi;
  logic                    we_lo;

  // Writes are suppressed while reset is held so the table survives a reset pulse.
  assign we_hi = wren & ena_a[1] & rst_n;
  assign we_lo = wren & ena_a[0] & rst_n;

  always_ff @(posedge clock) begin
    if (we_hi) begin
      mem_hi_q[wraddress] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (we_lo) begin
      mem_lo_q[wraddress] <= data;
    end
  end

  // Same-edge read of a written address returns the pre-write contents.
  assign q_d = {mem_hi_q[rdaddress], mem_lo_q[rdaddress]};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_denise_colortable_ram_mf.sv
// tb/tb_denise_colortable_ram_mf.sv - self-checking bench for denise_colortable_ram_mf
module tb_denise_colortable_ram_mf;

  logic        clock;
  logic        rst_n;
  logic [7:0]  wraddress;
  logic        wren;
  logic [1:0]  ena_a;
  logic [11:0] data;
  logic [7:0]  rdaddress;
  logic [23:0] q;

  logic [23:0] model [256];
  int n_total;
  int n_pass;

  denise_colortable_ram_mf #(.ADDR_WIDTH(8), .HALF_WIDTH(12)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .wraddress (wraddress),
    .wren      (wren),
    .ena_a     (ena_a),
    .data      (data),
    .rdaddress (rdaddress),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: an entry is two independent 12-bit halves selected by the enable bits.
  function automatic logic [23:0] merge(input logic [23:0] old, input logic [1:0] e,
                                        input logic [11:0] d);
    int hi;
    int lo;
    hi = e[1] ? int'(d) : int'(old) / 4096;
    lo = e[0] ? int'(d) : int'(old) % 4096;
    return 24'(hi * 4096 + lo);
  endfunction

  // One clock: drive at negedge, update model at posedge, return expected q at next negedge.
  task automatic cycle(input logic w, input logic [1:0] e, input logic [7:0] wa,
                       input logic [11:0] d, input logic [7:0] ra, output logic [23:0] exp_q);
    wren = w; ena_a = e; wraddress = wa; data = d; rdaddress = ra;
    @(posedge clock);
    exp_q = model[ra];
    if (w && rst_n) model[wa] = merge(model[wa], e, d);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [23:0] e;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if (q !== 24'h000000) $display("FAIL reset_q got=%h exp=%h", q, 24'h000000);
    else n_pass++;
    rst_n = 1'b1;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h00, e);
    n_total++;
    if (q !== e || e !== 24'h000000) $display("FAIL reset_first_read got=%h exp=%h", q, 24'h000000);
    else n_pass++;
  endtask

  task automatic test_full_write();
    logic [23:0] e;
    cycle(1'b1, 2'b11, 8'h05, 12'hABC, 8'h00, e);
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'hABCABC) $display("FAIL full_write got=%h exp=%h", q, 24'hABCABC);
    else n_pass++;
  endtask

  task automatic test_loct();
    logic [23:0] e;
    cycle(1'b1, 2'b01, 8'h05, 12'h123, 8'h05, e);
    n_total++;
    if (q !== 24'hABCABC) $display("FAIL loct_old got=%h exp=%h", q, 24'hABCABC);
    else n_pass++;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'hABC123) $display("FAIL loct_write got=%h exp=%h", q, 24'hABC123);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (q !== 24'h000000) $display("FAIL async_clear got=%h exp=%h", q, 24'h000000);
    else n_pass++;
    // Attempted write while reset is held must be discarded.
    wren = 1'b1; ena_a = 2'b11; wraddress = 8'h05; data = 12'hFFF; rdaddress = 8'h05;
    @(posedge clock);
    @(negedge clock);
    n_total++;
    if (q !== 24'h000000) $display("FAIL reset_hold got=%h exp=%h", q, 24'h000000);
    else n_pass++;
    wren = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'hABC123) $display("FAIL reset_mem_intact got=%h exp=%h", q, 24'hABC123);
    else n_pass++;
  endtask

  task automatic test_high_gating();
    logic [23:0] e;
    cycle(1'b1, 2'b10, 8'h05, 12'h777, 8'h00, e);
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'h777123) $display("FAIL high_half got=%h exp=%h", q, 24'h777123);
    else n_pass++;
    cycle(1'b0, 2'b11, 8'h05, 12'hFFF, 8'h00, e);
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'h777123) $display("FAIL wren_gate got=%h exp=%h", q, 24'h777123);
    else n_pass++;
    cycle(1'b1, 2'b00, 8'h05, 12'hFFF, 8'h00, e);
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h05, e);
    n_total++;
    if (q !== 24'h777123) $display("FAIL ena_none got=%h exp=%h", q, 24'h777123);
    else n_pass++;
  endtask

  task automatic test_rdw();
    logic [23:0] e;
    cycle(1'b1, 2'b11, 8'hFF, 12'h5A5, 8'hFF, e);
    n_total++;
    if (q !== 24'h000000) $display("FAIL rdw_old got=%h exp=%h", q, 24'h000000);
    else n_pass++;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'hFF, e);
    n_total++;
    if (q !== 24'h5A55A5) $display("FAIL rdw_new got=%h exp=%h", q, 24'h5A55A5);
    else n_pass++;
  endtask

  task automatic test_addr_independence();
    logic [23:0] e;
    cycle(1'b1, 2'b11, 8'h00, 12'h3C3, 8'h00, e);
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h00, e);
    n_total++;
    if (q !== 24'h3C33C3) $display("FAIL addr_00 got=%h exp=%h", q, 24'h3C33C3);
    else n_pass++;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'hFF, e);
    n_total++;
    if (q !== 24'h5A55A5) $display("FAIL addr_ff got=%h exp=%h", q, 24'h5A55A5);
    else n_pass++;
    cycle(1'b0, 2'b00, 8'h00, 12'h000, 8'h80, e);
    n_total++;
    if (q !== 24'h000000) $display("FAIL addr_80 got=%h exp=%h", q, 24'h000000);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [23:0] e;
    logic [7:0]  wa;
    logic [7:0]  ra;
    for (int i = 0; i < 400; i++) begin
      // Mix a narrow address window (frequent collisions) with full-range addresses.
      wa = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ra = (i % 3 == 0) ? wa : ((i % 3 == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom));
      cycle(1'($urandom), 2'($urandom), wa, 12'($urandom), ra, e);
      n_total++;
      if (q !== e) $display("FAIL random_%0d ra=%h got=%h exp=%h", i, ra, q, e);
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) model[i] = 24'h000000;
    rst_n = 1'b0;
    wren = 1'b0; ena_a = 2'b00; wraddress = 8'h00; data = 12'h000; rdaddress = 8'h00;
    test_reset();
    test_full_write();
    test_loct();
    test_async_reset();
    test_high_gating();
    test_rdw();
    test_addr_independence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
